id_ex_alu_ctrl: RTL and testbench
=================================

// Module: id_ex_alu_ctrl
// PURPOSE
//   ID/EX pipeline register directly upstream of the 32-bit ALU built from 1-bit slices.
//   Decodes ALUOp/funct into slice controls (sel[1:0], binvert, cin) and picks operand B.
//   Registers operands, destination and MEM/WB control bits for the EX stage.
//   Supports hazard-unit stall (hold) and branch flush (bubble insertion).
// PARAMETERS
//   DATA_W  32  operand / immediate width
//   REG_AW   5  register-address width
// PORTS
//   clk             in   1        rising-edge clock
//   rst_n           in   1        asynchronous active-low reset
//   stall           in   1        1 = hold all EX outputs
//   flush           in   1        1 = load a bubble next edge
//   id_valid        in   1        ID slot holds a real instruction
//   id_rs_data      in   DATA_W   register-file read A
//   id_rt_data      in   DATA_W   register-file read B
//   id_imm          in   DATA_W   sign-extended immediate
//   id_rt_addr      in   REG_AW   rt field
//   id_rd_addr      in   REG_AW   rd field
//   id_aluop        in   2        00 add, 01 sub, 10 R-type by funct, 11 OR
//   id_funct        in   6        funct field
//   id_alusrc       in   1        1 = operand B is immediate
//   id_regdst       in   1        1 = destination is rd, else rt
//   id_regwrite, id_memread, id_memwrite, id_memtoreg  in 1 each  downstream controls
//   ex_valid        out  1        EX slot holds a real instruction
//   ex_op_a         out  DATA_W   ALU operand A (= rs_data)
//   ex_op_b         out  DATA_W   ALU operand B (mux on alusrc)
//   ex_store_data   out  DATA_W   rt_data for stores
//   ex_sel          out  2        slice result mux: 00 AND, 01 OR, 10 SUM, 11 LESS
//   ex_binvert      out  1        invert B in every slice
//   ex_cin          out  1        carry into slice 0
//   ex_dst          out  REG_AW   destination register
//   ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out 1 each
//   ex_illegal      out  1        undefined funct under aluop=10
// BEHAVIOUR
//   - All outputs registered; latency 1 cycle ID->EX. No combinational in->out path.
//   - rst_n low (async): every output 0 immediately; held 0 until first edge after release.
//   - Edge priority: flush > stall > load.
//   - flush=1: all outputs cleared to 0 (bubble), regardless of stall or id_valid.
//   - stall=1, flush=0: every output holds its value; ID inputs ignored.
//   - Load: id_valid=0 loads a bubble (all 0); id_valid=1 captures decode below.
//   - Decode (sel,binvert,cin): add -> 10,0,0; sub -> 10,1,1; and -> 00,0,0;
//     or -> 01,0,0; slt -> 11,1,1.
//   - aluop 00 -> add; 01 -> sub; 11 -> or;
//     10 -> funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
//   - Undefined funct with aluop=10: decode as add, ex_illegal=1; all four control
//     enables (regwrite/memread/memwrite/memtoreg) forced 0; ex_valid=1.
//   - ex_op_b = alusrc ? imm : rt_data. ex_dst = regdst ? rd_addr : rt_addr.
//   - ex_op_a / ex_op_b / ex_store_data pass through unmodified; no width change.
//   - memread and memwrite both 1: captured as given. Detecting this is the
//     decoder's responsibility, not this block's.
// TESTING
//   1. rst_n=0 mid-stream with outputs nonzero -> every output 0 with no clock edge.
//   2. aluop=10, funct=101010, rs=5, rt=7, regdst=1, rd=3 -> next edge: sel=11,
//      binvert=1, cin=1, op_a=5, op_b=7, dst=3, valid=1.
//   3. aluop=00, alusrc=1, imm=0xFFFFFFFC, memread=1 -> op_b=0xFFFFFFFC, sel=10,
//      binvert=0, cin=0, memread=1.
//   4. Load sub; then stall=1 for 3 cycles while ID inputs change -> outputs unchanged;
//      stall=0 -> new ID values captured on the next edge.
//   5. stall=1 and flush=1 on the same edge -> bubble (valid=0, all enables 0).
//   6. aluop=10, funct=000111, regwrite=1 -> illegal=1, regwrite=0, sel=10, valid=1.

Source files
------------

// File: rtl/id_ex_alu_ctrl.sv
// ID/EX pipeline register for the 1-bit-slice ALU.
// Decodes ALUOp/funct into slice controls (sel, binvert, cin), selects
// operand B and the destination register, and registers everything the EX
// stage needs. A flush inserts a bubble. A stall holds the current contents.
module id_ex_alu_ctrl #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic [1:0]        id_aluop,
  input  logic [5:0]        id_funct,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [1:0]        ex_sel,
  output logic              ex_binvert,
  output logic              ex_cin,
  output logic [REG_AW-1:0] ex_dst,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_illegal
);

  // Per-slice result mux encoding.
  localparam logic [1:0] SEL_AND  = 2'b00;
  localparam logic [1:0] SEL_OR   = 2'b01;
  localparam logic [1:0] SEL_SUM  = 2'b10;
  localparam logic [1:0] SEL_LESS = 2'b11;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } aluop_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Everything the EX stage sees. An all-zero value is a bubble.
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] store_data;
    logic [1:0]        sel;
    logic              binvert;
    logic              cin;
    logic [REG_AW-1:0] dst;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              memtoreg;
    logic              illegal;
  } ex_t;

  ex_t        ex_q, ex_d;
  logic [1:0] dec_sel;
  logic       dec_binvert;
  logic       dec_cin;
  logic       dec_illegal;

  // Decode ALUOp/funct into slice controls. Undefined R-type funct decodes as add.
  always_comb begin
    // NOTE: every output gets a default before the case; otherwise a path
    // that skips an assignment would infer a latch.
    dec_sel     = SEL_SUM;
    dec_binvert = 1'b0;
    dec_cin     = 1'b0;
    dec_illegal = 1'b0;
    unique case (aluop_e'(id_aluop))
      ALUOP_ADD: ;
      ALUOP_SUB: begin
        dec_binvert = 1'b1;
        dec_cin     = 1'b1;
      end
      ALUOP_OR: dec_sel = SEL_OR;
      ALUOP_RTYPE: begin
        case (id_funct)
          FUNCT_ADD: ;
          FUNCT_SUB: begin
            dec_binvert = 1'b1;
            dec_cin     = 1'b1;
          end
          FUNCT_AND: dec_sel = SEL_AND;
          FUNCT_OR:  dec_sel = SEL_OR;
          FUNCT_SLT: begin
            dec_sel     = SEL_LESS;
            dec_binvert = 1'b1;
            dec_cin     = 1'b1;
          end
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  // Next EX contents: flush beats stall, stall beats load.
  always_comb begin
    ex_d = ex_q;
    if (flush) begin
      ex_d = '0;
    end else if (stall) begin
      ex_d = ex_q;
    end else if (!id_valid) begin
      ex_d = '0;
    end else begin
      ex_d.valid      = 1'b1;
      ex_d.op_a       = id_rs_data;
      ex_d.op_b       = id_alusrc ? id_imm : id_rt_data;
      ex_d.store_data = id_rt_data;
      ex_d.sel        = dec_sel;
      ex_d.binvert    = dec_binvert;
      ex_d.cin        = dec_cin;
      ex_d.dst        = id_regdst ? id_rd_addr : id_rt_addr;
      // An illegal instruction travels on but must not change machine state.
      ex_d.regwrite   = id_regwrite & ~dec_illegal;
      ex_d.memread    = id_memread  & ~dec_illegal;
      ex_d.memwrite   = id_memwrite & ~dec_illegal;
      ex_d.memtoreg   = id_memtoreg & ~dec_illegal;
      ex_d.illegal    = dec_illegal;
    end
  end

  // Pipeline register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples its inputs from before the edge.
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_op_a       = ex_q.op_a;
  assign ex_op_b       = ex_q.op_b;
  assign ex_store_data = ex_q.store_data;
  assign ex_sel        = ex_q.sel;
  assign ex_binvert    = ex_q.binvert;
  assign ex_cin        = ex_q.cin;
  assign ex_dst        = ex_q.dst;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_memtoreg   = ex_q.memtoreg;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_ctrl.sv
// Directed bench for id_ex_alu_ctrl: reset, decode of every operation,
// operand/destination muxing, stall hold, flush priority, illegal funct.
module tb_id_ex_alu_ctrl;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall, flush, id_valid;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [REG_AW-1:0] id_rt_addr, id_rd_addr;
  logic [1:0]        id_aluop;
  logic [5:0]        id_funct;
  logic              id_alusrc, id_regdst;
  logic              id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_op_a, ex_op_b, ex_store_data;
  logic [1:0]        ex_sel;
  logic              ex_binvert, ex_cin;
  logic [REG_AW-1:0] ex_dst;
  logic              ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_alu_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr), .id_aluop(id_aluop),
    .id_funct(id_funct), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_memtoreg(id_memtoreg), .ex_valid(ex_valid), .ex_op_a(ex_op_a),
    .ex_op_b(ex_op_b), .ex_store_data(ex_store_data), .ex_sel(ex_sel),
    .ex_binvert(ex_binvert), .ex_cin(ex_cin), .ex_dst(ex_dst),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every EX output against the expected values.
  task automatic expect_ex(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] sd,
                           input logic [1:0] sel, input logic binv, input logic cin,
                           input logic [4:0] dst, input logic rw, input logic mr,
                           input logic mw, input logic mtr, input logic ill);
    check({tag, ".valid"},   32'(ex_valid),   32'(v));
    check({tag, ".op_a"},    ex_op_a,         a);
    check({tag, ".op_b"},    ex_op_b,         b);
    check({tag, ".store"},   ex_store_data,   sd);
    check({tag, ".sel"},     32'(ex_sel),     32'(sel));
    check({tag, ".binvert"}, 32'(ex_binvert), 32'(binv));
    check({tag, ".cin"},     32'(ex_cin),     32'(cin));
    check({tag, ".dst"},     32'(ex_dst),     32'(dst));
    check({tag, ".regwr"},   32'(ex_regwrite), 32'(rw));
    check({tag, ".memrd"},   32'(ex_memread),  32'(mr));
    check({tag, ".memwr"},   32'(ex_memwrite), 32'(mw));
    check({tag, ".mem2reg"}, 32'(ex_memtoreg), 32'(mtr));
    check({tag, ".illegal"}, 32'(ex_illegal),  32'(ill));
  endtask

  task automatic drive(input logic v, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] imm, input logic [4:0] rta, input logic [4:0] rda,
                       input logic [1:0] op, input logic [5:0] fn, input logic src,
                       input logic dst, input logic rw, input logic mr, input logic mw,
                       input logic mtr);
    id_valid = v;     id_rs_data = rs;   id_rt_data = rt;   id_imm = imm;
    id_rt_addr = rta; id_rd_addr = rda;  id_aluop = op;     id_funct = fn;
    id_alusrc = src;  id_regdst = dst;   id_regwrite = rw;  id_memread = mr;
    id_memwrite = mw; id_memtoreg = mtr;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 2'b00, 6'd0, 0, 0, 1, 1, 1, 1);
    #1;
    expect_ex("reset", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    expect_ex("reset_edge", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // slt via R-type, destination rd.
    drive(1, 32'd5, 32'd7, 32'h0, 5'd4, 5'd3, 2'b10, 6'b101010, 0, 1, 1, 0, 0, 0);
    step();
    expect_ex("slt", 1, 32'd5, 32'd7, 32'd7, 2'b11, 1, 1, 5'd3, 1, 0, 0, 0, 0);

    // Load-style add with negative immediate, destination rt.
    @(negedge clk);
    drive(1, 32'h11, 32'd7, 32'hFFFF_FFFC, 5'd4, 5'd9, 2'b00, 6'b000000, 1, 0, 1, 1, 0, 1);
    step();
    expect_ex("lw_add", 1, 32'h11, 32'hFFFF_FFFC, 32'd7, 2'b10, 0, 0, 5'd4, 1, 1, 0, 1, 0);

    // R-type add, and, or, sub.
    @(negedge clk);
    drive(1, 32'hA5A5_0000, 32'h0000_5A5A, 32'h0, 5'd6, 5'd7, 2'b10, 6'b100000, 0, 1, 1, 0, 0, 0);
    step();
    expect_ex("r_add", 1, 32'hA5A5_0000, 32'h0000_5A5A, 32'h0000_5A5A, 2'b10, 0, 0, 5'd7, 1, 0, 0, 0, 0);
    @(negedge clk);
    id_funct = 6'b100100;
    step();
    check("r_and.sel", 32'(ex_sel), 32'd0);
    check("r_and.binvert", 32'(ex_binvert), 32'd0);
    @(negedge clk);
    id_funct = 6'b100101;
    step();
    check("r_or.sel", 32'(ex_sel), 32'd1);
    @(negedge clk);
    id_funct = 6'b100010;
    step();
    check("r_sub.sel", 32'(ex_sel), 32'd2);
    check("r_sub.binvert", 32'(ex_binvert), 32'd1);
    check("r_sub.cin", 32'(ex_cin), 32'd1);

    // aluop 11 (ori): OR with immediate.
    @(negedge clk);
    drive(1, 32'h0F0F_0F0F, 32'h1234_5678, 32'h0000_FFFF, 5'd12, 5'd13, 2'b11, 6'b000000, 1, 0, 1, 0, 0, 0);
    step();
    expect_ex("ori", 1, 32'h0F0F_0F0F, 32'h0000_FFFF, 32'h1234_5678, 2'b01, 0, 0, 5'd12, 1, 0, 0, 0, 0);

    // Store with memread and memwrite both set: passed through as given.
    @(negedge clk);
    drive(1, 32'h100, 32'hDEAD_BEEF, 32'h8, 5'd2, 5'd31, 2'b00, 6'b000000, 1, 0, 0, 1, 1, 0);
    step();
    expect_ex("sw_both", 1, 32'h100, 32'h8, 32'hDEAD_BEEF, 2'b10, 0, 0, 5'd2, 0, 1, 1, 0, 0);

    // id_valid=0 loads a bubble.
    @(negedge clk);
    drive(0, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 2'b01, 6'd0, 1, 1, 1, 1, 1, 1);
    step();
    expect_ex("bubble", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load sub, then stall three cycles while ID changes.
    @(negedge clk);
    drive(1, 32'd100, 32'd30, 32'h0, 5'd8, 5'd10, 2'b01, 6'd0, 0, 1, 1, 0, 0, 0);
    step();
    expect_ex("sub", 1, 32'd100, 32'd30, 32'd30, 2'b10, 1, 1, 5'd10, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stall = 1'b1;
      drive(1, 32'd200 + 32'(i), 32'd9, 32'h44, 5'd1, 5'd2, 2'b11, 6'd0, 1, 0, 0, 1, 1, 1);
      step();
      expect_ex($sformatf("stall%0d", i), 1, 32'd100, 32'd30, 32'd30, 2'b10, 1, 1, 5'd10, 1, 0, 0, 0, 0);
    end
    @(negedge clk);
    stall = 1'b0;
    step();
    expect_ex("unstall", 1, 32'd202, 32'h44, 32'd9, 2'b01, 0, 0, 5'd1, 0, 1, 1, 1, 0);

    // stall and flush together: flush wins.
    @(negedge clk);
    stall = 1'b1; flush = 1'b1;
    step();
    expect_ex("stall_flush", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // flush alone with a valid ID instruction.
    @(negedge clk);
    stall = 1'b0; flush = 1'b0;
    drive(1, 32'd1, 32'd2, 32'h0, 5'd3, 5'd4, 2'b00, 6'd0, 0, 0, 1, 0, 0, 0);
    step();
    check("preflush.valid", 32'(ex_valid), 32'd1);
    @(negedge clk);
    flush = 1'b1;
    step();
    expect_ex("flush", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);

    // Undefined funct: decoded as add, enables forced off, still valid.
    @(negedge clk);
    flush = 1'b0;
    drive(1, 32'd3, 32'd4, 32'h0, 5'd5, 5'd6, 2'b10, 6'b000111, 0, 1, 1, 1, 1, 1);
    step();
    expect_ex("illegal", 1, 32'd3, 32'd4, 32'd4, 2'b10, 0, 0, 5'd6, 0, 0, 0, 0, 1);

    // Mid-stream async reset with nonzero outputs, no clock edge involved.
    @(negedge clk);
    drive(1, 32'hCAFE_F00D, 32'h1357_9BDF, 32'h0, 5'd17, 5'd18, 2'b10, 6'b101010, 0, 1, 1, 1, 1, 1);
    step();
    check("pre_reset.op_a", ex_op_a, 32'hCAFE_F00D);
    #2;
    rst_n = 1'b0;
    #1;
    expect_ex("async_reset", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    expect_ex("reset_hold", 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    expect_ex("post_reset", 1, 32'hCAFE_F00D, 32'h1357_9BDF, 32'h1357_9BDF, 2'b11, 1, 1, 5'd18, 1, 1, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
